data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Multi-cycle load/store controller directly downstream of the rv32i DataPath.
- Consumes aluRes (address), writeData and the funct3 size code. Drives a variable-latency word-wide memory bus and returns sign- or zero-extended readData to the DataPath.
- Raises stall while an access is outstanding, so the single-cycle core freezes PC and regWrite until the access completes.

Parameters:
- ADDR_W, 16, bus byte-address width; matches the 16-bit pc/address space.
- TIMEOUT_CYC, 255, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- memRead  in  1  load request from control unit
- memWrite  in  1  store request from control unit
- f3  in  3  funct3 size/sign code
- addr  in  32  byte address (DataPath aluRes); only [ADDR_W-1:0] used
- writeData  in  32  store data (rs2)
- readData  out  32  extended load result to DataPath
- stall  out  1  freeze PC/regWrite while high
- accessErr  out  1  one-cycle pulse on a misaligned/illegal access (or timeout)
- busValid  out  1  bus request valid
- busReady  in  1  bus accepts request
- busWe  out  1  1 = write
- busAddr  out  ADDR_W  word-aligned address ([1:0] = 0)
- busBe  out  4  byte enables
- busWdata  out  32  lane-shifted store data
- busRvalid  in  1  read data valid
- busRdata  in  32  read word

Behaviour:
- Reset: state IDLE; readData = 0, stall = 0, accessErr = 0, busValid = 0, busWe = 0, busAddr = 0, busBe = 0, busWdata = 0.
- Sizes:
  - f3 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU (loads only).
  - Stores accept only 000/010/001.
  - Any other f3 is illegal.
- Misaligned: H/HU with addr[0] = 1; W with addr[1:0] ≠ 0.
- Illegal also covers memRead and memWrite high together.
- IDLE:
  - If a request is legal: latch addr/f3/data/byte-lane info; stall = 1 combinationally that same cycle; go to REQ.
  - If a request is illegal or misaligned: accessErr = 1 for that cycle, stall = 0, no bus activity, readData unchanged, stay in IDLE.
- REQ:
  - busValid = 1 with busAddr = {addr[ADDR_W-1:2], 2'b00}.
  - busBe: B = 0001 << addr[1:0]; H = 0011 << {addr[1], 0}; W = 1111.
  - busWdata: store byte/half replicated to all lanes.
  - All bus outputs are held stable until busReady.
  - On busValid & busReady: a write goes to DONE; a read goes to WAIT_R.
- WAIT_R: on busRvalid, select the lane by the latched addr[1:0], sign- or zero-extend per f3, register into readData, go to DONE.
- DONE:
  - stall = 0 for exactly this cycle, so the core retires the instruction at this edge.
  - Next state IDLE.
  - The next request is evaluated in IDLE on the following cycle.
- Latency:
  - Store: 2 + n cycles of stall, where n = busReady wait cycles.
  - Load: additionally plus the cycles until busRvalid.
  - Zero-wait store: stall high for 2 cycles (IDLE, REQ), low in DONE.
- readData holds its last load value until the next load completes; stores do not change it.
- busRvalid outside WAIT_R is ignored.
- Synchronous reset in any state returns to IDLE on that edge: busValid drops, stall drops, and the pending access is abandoned.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+ bit counter runs in REQ/WAIT_R and clears on entering REQ.
  - When it reaches TIMEOUT_CYC: abort to DONE, pulse accessErr, readData = 0 for a read, busValid = 0.
- Undefined: no counter; the controller waits indefinitely.

Decomposition:
- Shared package rv_mem_pkg:
  - f3 size constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding: IDLE, REQ, WAIT_R, DONE.
  - function for the byte-enable mask.
- One sub-module, load_align: combinational lane select plus sign/zero extension from rdata, addr[1:0] and f3.

Test Plan:
- SW addr = 0x0010, data = 0xDEADBEEF, busReady tied 1 -> busValid for 1 cycle, busBe = 1111, busAddr = 0x0010, stall high 2 cycles then low.
- SB addr = 0x0013, data = 0x000000A5 -> busBe = 1000, busWdata = 0xA5A5A5A5, busAddr = 0x0010.
- LB addr = 0x0011, busRdata = 0x12348056, busRvalid 3 cycles after ready -> readData = 0xFFFFFF80; LBU -> 0x00000080; LH at 0x0012 -> 0x00001234.
- LW addr = 0x0006 -> accessErr pulse 1 cycle, stall = 0, busValid never asserts, readData unchanged.
- busReady held low 4 cycles -> busValid/busAddr/busBe stable all 4 cycles, stall stays high; rst_n low in the 3rd cycle -> next edge IDLE, busValid = 0, stall = 0.
- MEM_TIMEOUT_EN with TIMEOUT_CYC = 8, LW with busRvalid never asserted -> accessErr pulse after 8 cycles, readData = 0, return to IDLE.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: funct3 size codes,
// controller state encoding and the byte-enable mask helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Byte lanes touched by an access of size f3 at byte offset lo.
    function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        m = '0;
        case (f3)
            F3_B, F3_BU: m = 4'b0001 << lo;
            F3_H, F3_HU: m = 4'b0011 << {lo[1], 1'b0};
            F3_W:        m = 4'b1111;
            default:     m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-wide variable-latency memory bus between the controller (master)
// and the memory (slave).
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              busValid;
    logic              busReady;
    logic              busWe;
    logic [ADDR_W-1:0] busAddr;
    logic [3:0]        busBe;
    logic [31:0]       busWdata;
    logic              busRvalid;
    logic [31:0]       busRdata;

    modport master (
        output busValid, busWe, busAddr, busBe, busWdata,
        input  busReady, busRvalid, busRdata
    );

    modport slave (
        input  busValid, busWe, busAddr, busBe, busWdata,
        output busReady, busRvalid, busRdata
    );
endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// Load alignment: picks the addressed byte/half out of the bus word and
// sign- or zero-extends it according to funct3.
module load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lo,
    input  logic [2:0]  i_f3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select and extension
    always_comb begin
        w_byte = '0;
        case (i_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = '0;
        endcase
        w_half = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        o_data = '0;
        case (i_f3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_rdata;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store controller between the rv32i DataPath and a
// variable-latency word bus. Stalls the core while an access is in flight.
// Optional watchdog abort: define MEM_TIMEOUT_EN.
module data_mem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   memRead,
    input  logic                   memWrite,
    input  logic [2:0]             f3,
    input  logic [31:0]            addr,
    input  logic [31:0]            writeData,
    output logic [31:0]            readData,
    output logic                   stall,
    output logic                   accessErr,
    data_mem_ctrl_if.master        bus
);

    mem_state_t        r_state;
    mem_state_t        w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_readData;

    logic              w_req;
    logic              w_size_ok;
    logic              w_misal;
    logic              w_bad;
    logic              w_accept;
    logic              w_stall;
    logic              w_err;
    logic              w_busValid;
    logic              w_tout;
    logic [31:0]       w_lanes;
    logic [31:0]       w_load;
    logic              w_unused_addr_hi;

    // Only the low ADDR_W address bits reach the bus.
    assign w_unused_addr_hi = ^addr[31:ADDR_W];

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] r_cnt;
`else
    localparam int w_unused_timeout = TIMEOUT_CYC;
`endif

    // Request legality: size code, alignment and read/write conflict
    always_comb begin
        w_req     = memRead | memWrite;
        w_size_ok = 1'b0;
        if (memWrite) begin
            w_size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            w_size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
        end
        w_misal  = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
                   ((f3 == F3_W) && (addr[1:0] != 2'b00));
        w_bad    = (memRead && memWrite) || !w_size_ok || w_misal;
        w_accept = (r_state == IDLE) && w_req && !w_bad;
    end

    // Store data replicated across all byte lanes
    always_comb begin
        w_lanes = writeData;
        case (f3)
            F3_B:    w_lanes = {4{writeData[7:0]}};
            F3_H:    w_lanes = {2{writeData[15:0]}};
            default: w_lanes = writeData;
        endcase
    end

    load_align u_load_align (
        .i_rdata (bus.busRdata),
        .i_lo    (r_addr[1:0]),
        .i_f3    (r_f3),
        .o_data  (w_load)
    );

    // Next-state and output decode
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_err      = 1'b0;
        w_busValid = 1'b0;
        w_tout     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_bad) begin
                        w_err = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_next  = REQ;
                    end
                end
            end
            REQ: begin
                w_stall    = 1'b1;
                w_busValid = 1'b1;
                if (bus.busReady) begin
                    w_next = r_we ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                w_stall = 1'b1;
                if (bus.busRvalid) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
`ifdef MEM_TIMEOUT_EN
        // Watchdog overrides any handshake completing in the same cycle.
        if (((r_state == REQ) || (r_state == WAIT_R)) &&
            (r_cnt == CNT_W'(TIMEOUT_CYC))) begin
            w_tout     = 1'b1;
            w_err      = 1'b1;
            w_busValid = 1'b0;
            w_next     = DONE;
        end
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the accepted request for the duration of the access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_f3    <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= addr[ADDR_W-1:0];
            r_f3    <= f3;
            r_we    <= memWrite;
            r_be    <= be_mask(f3, addr[1:0]);
            r_wdata <= w_lanes;
        end
    end

    // Load result register; holds until the next completed load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_readData <= '0;
        end else if (w_tout) begin
            if (!r_we) begin
                r_readData <= '0;
            end
        end else if ((r_state == WAIT_R) && bus.busRvalid) begin
            r_readData <= w_load;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Watchdog counter: cleared while idle, counts REQ/WAIT_R cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == REQ) || (r_state == WAIT_R)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`endif

    assign readData      = r_readData;
    assign stall         = w_stall;
    assign accessErr     = w_err;
    assign bus.busValid  = w_busValid;
    assign bus.busWe     = w_busValid & r_we;
    assign bus.busAddr   = w_busValid ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign bus.busBe     = w_busValid ? r_be : '0;
    assign bus.busWdata  = w_busValid ? r_wdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of load/store vectors plus
// hand sequences for reset-during-access and (optionally) the watchdog.
module tb_data_mem_ctrl;
    import rv_mem_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        accessErr;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_ctrl_if #(.ADDR_W(16)) ifc ();

    data_mem_ctrl #(.ADDR_W(16), .TIMEOUT_CYC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .f3        (f3),
        .addr      (addr),
        .writeData (writeData),
        .readData  (readData),
        .stall     (stall),
        .accessErr (accessErr),
        .bus       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rw;    // cycles busReady held low
        int          vw;    // WAIT_R cycles before busRvalid
        logic        err;
        logic [3:0]  be;
        logic [15:0] ba;
        logic [31:0] ewd;
        int          stl;   // expected stall-high cycles
        logic [31:0] erd;   // expected readData afterwards
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        memRead   = 1'b0;
        memWrite  = 1'b0;
        f3        = 3'b000;
        addr      = '0;
        writeData = '0;
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic run_vec(input int i, input vec_t v);
        int  stl;
        int  vcnt;
        int  wcnt;
        bit  hs;
        bit  hs_now;
        bit  checked;
        bit  done;
        memRead   = v.rd;
        memWrite  = v.wr;
        f3        = v.f3;
        addr      = v.addr;
        writeData = v.wdata;
        ifc.busReady  = 1'b0;
        ifc.busRvalid = 1'b0;
        if (v.err) begin
            #1;
            chk($sformatf("v%0d_err_pulse", i), {29'd0, accessErr, stall, ifc.busValid}, 32'h4);
            @(posedge clk); #1;
            idle_inputs();
            #1;
            chk($sformatf("v%0d_err_after", i), {31'd0, ifc.busValid | stall | accessErr}, 32'h0);
            chk($sformatf("v%0d_rd_kept", i), readData, v.erd);
            return;
        end
        stl = 0; vcnt = 0; wcnt = 0; hs = 0; checked = 0; done = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!stall) begin
                done = 1;
                break;
            end
            stl++;
            if (ifc.busValid) begin
                if (!checked) begin
                    chk($sformatf("v%0d_busBe", i), {28'd0, ifc.busBe}, {28'd0, v.be});
                    chk($sformatf("v%0d_busAddr", i), {16'd0, ifc.busAddr}, {16'd0, v.ba});
                    chk($sformatf("v%0d_busWe", i), {31'd0, ifc.busWe}, {31'd0, v.wr});
                    if (v.wr) chk($sformatf("v%0d_busWdata", i), ifc.busWdata, v.ewd);
                    checked = 1;
                end
                ifc.busReady  = (vcnt >= v.rw);
                ifc.busRvalid = 1'b1;           // must be ignored outside WAIT_R
                ifc.busRdata  = 32'hBAD0_BAD0;
                vcnt++;
            end else if (hs) begin
                ifc.busRdata  = v.rdata;
                ifc.busRvalid = (wcnt >= v.vw);
                wcnt++;
            end
            hs_now = ifc.busValid && ifc.busReady;
            @(posedge clk); #1;
            if (hs_now) hs = 1;
            ifc.busReady  = 1'b0;
            ifc.busRvalid = 1'b0;
        end
        chk($sformatf("v%0d_completed", i), {31'd0, done}, 32'h1);
        chk($sformatf("v%0d_bus_seen", i), {31'd0, checked}, 32'h1);
        chk($sformatf("v%0d_stall_cycles", i), stl, v.stl);
        chk($sformatf("v%0d_readData", i), readData, v.erd);
        chk($sformatf("v%0d_done_busValid", i), {31'd0, ifc.busValid}, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk($sformatf("v%0d_back_idle", i), {30'd0, stall, ifc.busValid}, 32'h0);
    endtask

    initial begin
        logic [15:0] ba0;
        logic [3:0]  be0;
        int          idx;
        bit          seen;

        //          rd   wr   f3      addr          wdata         rdata         rw vw err be       ba        ewd           stl erd
        tbl[0]  = '{1'b0,1'b1,3'b010,32'hABCD_0010,32'hDEAD_BEEF,32'h0,        0, 0, 1'b0,4'b1111,16'h0010,32'hDEAD_BEEF,2,32'h0000_0000};
        tbl[1]  = '{1'b0,1'b1,3'b000,32'h0000_0013,32'h0000_00A5,32'h0,        0, 0, 1'b0,4'b1000,16'h0010,32'hA5A5_A5A5,2,32'h0000_0000};
        tbl[2]  = '{1'b0,1'b1,3'b001,32'h0000_0016,32'h0000_CAFE,32'h0,        2, 0, 1'b0,4'b1100,16'h0014,32'hCAFE_CAFE,4,32'h0000_0000};
        tbl[3]  = '{1'b1,1'b0,3'b000,32'h0000_0011,32'h0,        32'h1234_8056,0, 2, 1'b0,4'b0010,16'h0010,32'h0,        5,32'hFFFF_FF80};
        tbl[4]  = '{1'b1,1'b0,3'b100,32'h0000_0011,32'h0,        32'h1234_8056,1, 0, 1'b0,4'b0010,16'h0010,32'h0,        4,32'h0000_0080};
        tbl[5]  = '{1'b1,1'b0,3'b001,32'h0000_0012,32'h0,        32'h1234_8056,0, 0, 1'b0,4'b1100,16'h0010,32'h0,        3,32'h0000_1234};
        tbl[6]  = '{1'b1,1'b0,3'b010,32'h0000_0006,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h0000_1234};
        tbl[7]  = '{1'b1,1'b0,3'b001,32'h0000_0002,32'h0,        32'h8001_F00D,0, 0, 1'b0,4'b1100,16'h0000,32'h0,        3,32'hFFFF_8001};
        tbl[8]  = '{1'b1,1'b0,3'b101,32'h0000_0002,32'h0,        32'h8001_F00D,0, 1, 1'b0,4'b1100,16'h0000,32'h0,        4,32'h0000_8001};
        tbl[9]  = '{1'b1,1'b0,3'b010,32'h0000_0020,32'h0,        32'h89AB_CDEF,3, 3, 1'b0,4'b1111,16'h0020,32'h0,        9,32'h89AB_CDEF};
        tbl[10] = '{1'b0,1'b1,3'b010,32'h0000_0024,32'h1234_5678,32'h0,        1, 0, 1'b0,4'b1111,16'h0024,32'h1234_5678,3,32'h89AB_CDEF};
        tbl[11] = '{1'b0,1'b1,3'b001,32'h0000_0011,32'h0000_1111,32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h89AB_CDEF};
        tbl[12] = '{1'b1,1'b0,3'b011,32'h0000_0000,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h89AB_CDEF};
        tbl[13] = '{1'b0,1'b1,3'b100,32'h0000_0000,32'h0000_0055,32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h89AB_CDEF};
        tbl[14] = '{1'b1,1'b1,3'b010,32'h0000_0000,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h89AB_CDEF};
        tbl[15] = '{1'b1,1'b0,3'b000,32'h0000_0003,32'h0,        32'h7F00_0000,0, 0, 1'b0,4'b1000,16'h0000,32'h0,        3,32'h0000_007F};
        tbl[16] = '{1'b1,1'b0,3'b101,32'h0000_0001,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,16'h0000,32'h0,        0,32'h0000_007F};
        tbl[17] = '{1'b0,1'b1,3'b000,32'h0000_0002,32'h1234_56C3,32'h0,        0, 0, 1'b0,4'b0100,16'h0000,32'hC3C3_C3C3,2,32'h0000_007F};

        idle_inputs();
        ifc.busReady  = 1'b0;
        ifc.busRvalid = 1'b0;
        ifc.busRdata  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state",
            {readData[15:0], 10'd0, stall, accessErr, ifc.busValid, ifc.busWe, ifc.busBe != 4'd0, ifc.busAddr != 16'd0},
            32'h0);
        chk("reset_wdata", ifc.busWdata | readData, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            run_vec(i, tbl[i]);
        end

`ifdef MEM_TIMEOUT_EN
        // LW with busRvalid never arriving: watchdog aborts after 8 cycles.
        memRead = 1'b1; f3 = F3_W; addr = 32'h0000_0040;
        ifc.busReady = 1'b1;
        idx = -1;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (accessErr) begin
                idx = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("tout_err_cycle", idx, 9);
        chk("tout_busValid", {31'd0, ifc.busValid}, 32'h0);
        @(posedge clk); #1;
        ifc.busReady = 1'b0;
        #1;
        chk("tout_done", {30'd0, stall, accessErr}, 32'h0);
        chk("tout_readData", readData, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        #1;
        chk("tout_idle", {30'd0, stall, ifc.busValid}, 32'h0);
`endif

        // busReady held low; bus outputs must stay frozen; reset mid-wait.
        memWrite = 1'b1; f3 = F3_W; addr = 32'h0000_0030; writeData = 32'h1111_2222;
        ifc.busReady = 1'b0;
        @(posedge clk); #1;
        #1;
        ba0 = ifc.busAddr;
        be0 = ifc.busBe;
        chk("hold_c1", {ifc.busValid, stall, 10'd0, be0, ba0}, {1'b1, 1'b1, 10'd0, 4'b1111, 16'h0030});
        seen = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3) begin
                rst_n = 1'b0;
                idle_inputs();
            end
            #1;
            chk($sformatf("hold_c%0d", c), {ifc.busValid, ifc.busWe, stall, 9'd0, ifc.busBe, ifc.busAddr},
                {1'b1, 1'b1, 1'b1, 9'd0, be0, ba0});
            chk($sformatf("hold_wdata_c%0d", c), ifc.busWdata, 32'h1111_2222);
        end
        @(posedge clk); #1;
        #1;
        chk("rst_mid_idle", {29'd0, ifc.busValid, stall, accessErr}, 32'h0);
        chk("rst_mid_readData", readData, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(100, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
